// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: bus widths, access-width codes,
// FSM encoding and the execute-to-memory bus layout.
package mem_access_unit_pkg;

    localparam int ES_TO_MS_BUS_WD = 103;
    localparam int MS_TO_ES_BUS_WD = 34;

    localparam logic [3:0] BW_BYTE = 4'b0001;
    localparam logic [3:0] BW_HALF = 4'b0011;
    localparam logic [3:0] BW_WORD = 4'b1111;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_REQ  = 4'b0010,
        S_WAIT = 4'b0100,
        S_DONE = 4'b1000
    } mau_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        is_unsigned;
        logic        mem_we;
        logic        mem_re;
        logic [3:0]  bit_width;
        logic [31:0] st_data;
        logic [31:0] pc;
    } es_to_ms_t;

    // Unknown width codes behave as full-word accesses.
    function automatic logic [3:0] norm_width(input logic [3:0] bw);
        case (bw)
            BW_BYTE: return BW_BYTE;
            BW_HALF: return BW_HALF;
            default: return BW_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: store strobes/replicated data and load extract with sign/zero extend.
// Purely combinational so an uncached path can reuse it.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [3:0]  bit_width,
    input  logic        is_unsigned,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [3:0]  bw;
    logic [31:0] shifted;

    assign bw      = norm_width(bit_width);
    assign wstrb   = bw << addr_lo;
    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        wdata   = st_data;
        ld_data = shifted;
        case (bw)
            BW_BYTE: begin
                wdata   = {4{st_data[7:0]}};
                ld_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            end
            BW_HALF: begin
                wdata   = {2{st_data[15:0]}};
                ld_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                wdata   = st_data;
                ld_data = shifted;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage data-cache front end: one load/store transaction at a time over a
// valid/ready request plus data_ok response, with misalignment exception and load formatting.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter bit ALE_CHECK = 1'b1,
    parameter bit RESP_HOLD = 1'b1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       es_ready,
    output logic [MS_TO_ES_BUS_WD-1:0] ms_to_es_bus,
    output logic                       dc_req,
    output logic                       dc_wr,
    output logic [31:0]                dc_addr,
    output logic [3:0]                 dc_wstrb,
    output logic [31:0]                dc_wdata,
    input  logic                       dc_addr_ok,
    input  logic                       dc_data_ok,
    input  logic [31:0]                dc_rdata
);

    es_to_ms_t   es;
    mau_state_e  state_q, state_d;
    logic [31:0] rdata_q, ld_data, mem_result;
    logic [3:0]  width;
    logic        op, mis, dcache_ok;
    logic        unused_pc;

    assign es        = es_to_ms_t'(es_to_ms_bus);
    assign unused_pc = ^es.pc;
    assign width     = norm_width(es.bit_width);
    assign op        = es.mem_re | es.mem_we;
    assign mis       = ALE_CHECK && op &&
                       (((width == BW_HALF) && es.addr[0]) ||
                        ((width == BW_WORD) && (es.addr[1:0] != 2'b00)));

    mem_lane_align u_align (
        .addr_lo     (es.addr[1:0]),
        .bit_width   (es.bit_width),
        .is_unsigned (es.is_unsigned),
        .st_data     (es.st_data),
        .rdata       (dc_rdata),
        .wstrb       (dc_wstrb),
        .wdata       (dc_wdata),
        .ld_data     (ld_data)
    );

    // Request fields come straight from the bus; the execute stage holds it while stalled.
    assign dc_wr   = es.mem_we;
    assign dc_addr = {es.addr[31:2], 2'b00};

    assign ms_to_es_bus = {mis, dcache_ok, mem_result};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_WAIT && dc_data_ok)
                rdata_q <= es.mem_re ? ld_data : '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        dc_req     = 1'b0;
        dcache_ok  = 1'b0;
        mem_result = '0;
        case (state_q)
            S_IDLE: begin
                if (!op || mis) begin
                    dcache_ok = 1'b1;
                end else begin
                    dc_req  = 1'b1;
                    state_d = dc_addr_ok ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                dc_req = 1'b1;
                if (dc_addr_ok)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dc_data_ok) begin
                    if (RESP_HOLD) begin
                        state_d = S_DONE;
                    end else begin
                        // Without hold the result is only valid this cycle; if the stage
                        // is stalled elsewhere, fall back to DONE rather than drop the data.
                        dcache_ok  = 1'b1;
                        mem_result = es.mem_re ? ld_data : '0;
                        state_d    = es_ready ? S_IDLE : S_DONE;
                    end
                end
            end
            S_DONE: begin
                dcache_ok  = 1'b1;
                mem_result = rdata_q;
                if (es_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (!resetn) begin
            dc_req     = 1'b0;
            dcache_ok  = !op;
            mem_result = '0;
        end
    end

    // A response outside WAIT means the cache broke the one-outstanding contract.
    a_data_ok_in_wait: assert property (@(posedge clk) disable iff (!resetn)
        dc_data_ok |-> (state_q == S_WAIT));

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: scripted cache responder, scoreboard of
// expected load results/exceptions, per-scenario tasks.
module tb_mem_access_unit;

    logic         clk = 1'b0;
    logic         resetn;
    logic [102:0] es_to_ms_bus;
    logic         es_ready;
    logic [33:0]  ms_to_es_bus;
    logic         dc_req, dc_wr;
    logic [31:0]  dc_addr, dc_wdata;
    logic [3:0]   dc_wstrb;
    logic         dc_addr_ok, dc_data_ok;
    logic [31:0]  dc_rdata;

    logic         ale_o, ok_o;
    logic [31:0]  res_o;
    assign {ale_o, ok_o, res_o} = ms_to_es_bus;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] res;
        logic        ale;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int          ok_cycle;
        logic [31:0] res;
        logic        ale;
        int          req_cycles;
        int          first_req;
        int          hs;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        fields_moved;
        logic        res_moved;
        logic        ok_dropped;
        logic        timeout;
    } obs_t;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk          (clk),
        .resetn       (resetn),
        .es_to_ms_bus (es_to_ms_bus),
        .es_ready     (es_ready),
        .ms_to_es_bus (ms_to_es_bus),
        .dc_req       (dc_req),
        .dc_wr        (dc_wr),
        .dc_addr      (dc_addr),
        .dc_wstrb     (dc_wstrb),
        .dc_wdata     (dc_wdata),
        .dc_addr_ok   (dc_addr_ok),
        .dc_data_ok   (dc_data_ok),
        .dc_rdata     (dc_rdata)
    );

    task automatic set_bus(input logic [31:0] addr, input logic uns, input logic we,
                           input logic re, input logic [3:0] bw, input logic [31:0] st);
        es_to_ms_bus = {addr, uns, we, re, bw, st, 32'h0000_0000};
    endtask

    // Drives one instruction and plays a cache that accepts after aok_delay cycles and
    // answers the cycle after acceptance; holds es_ready low for `hold` extra ok cycles.
    task automatic do_txn(input logic [31:0] addr, input logic uns, input logic we,
                          input logic re, input logic [3:0] bw, input logic [31:0] st,
                          input int aok_delay, input int hold, input logic [31:0] rdata,
                          output obs_t o);
        bit accepted = 0;
        bit fin      = 0;
        int acc_k    = -10;
        int oks      = 0;
        o.ok_cycle = -1; o.res = '0; o.ale = 1'b0; o.req_cycles = 0; o.first_req = -1;
        o.hs = 0; o.wr = 1'b0; o.addr = '0; o.wstrb = '0; o.wdata = '0;
        o.fields_moved = 1'b0; o.res_moved = 1'b0; o.ok_dropped = 1'b0; o.timeout = 1'b0;
        @(posedge clk); #1;
        set_bus(addr, uns, we, re, bw, st);
        dc_rdata = rdata;
        for (int k = 0; k < 40 && !fin; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            dc_addr_ok = !accepted && (k >= aok_delay);
            dc_data_ok = accepted && (k == acc_k + 1);
            es_ready   = 1'b0;
            #1;
            if (dc_req) begin
                if (o.req_cycles == 0) begin
                    o.first_req = k; o.wr = dc_wr; o.addr = dc_addr;
                    o.wstrb = dc_wstrb; o.wdata = dc_wdata;
                end else if ({dc_wr, dc_addr, dc_wstrb, dc_wdata} !== {o.wr, o.addr, o.wstrb, o.wdata}) begin
                    o.fields_moved = 1'b1;
                end
                o.req_cycles++;
                if (dc_addr_ok && !accepted) begin accepted = 1; acc_k = k; o.hs++; end
            end
            if (ok_o) begin
                if (oks == 0) begin o.ok_cycle = k; o.res = res_o; o.ale = ale_o; end
                else if (res_o !== o.res) o.res_moved = 1'b1;
                oks++;
                if (oks > hold) begin es_ready = 1'b1; fin = 1; end
            end else if (oks > 0) begin
                o.ok_dropped = 1'b1;
            end
        end
        o.timeout = !fin;
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        set_bus(32'h0, 1'b0, 1'b0, 1'b0, 4'b1111, 32'h0);
        es_ready = 1'b0; dc_addr_ok = 1'b0; dc_data_ok = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; es_ready = 1'b0; dc_addr_ok = 1'b0; dc_data_ok = 1'b0; dc_rdata = '0;
        set_bus(32'h0, 1'b0, 1'b0, 1'b0, 4'b1111, 32'h0);
        #2;
        checks++; if (dc_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", dc_req); end
        checks++; if (ok_o !== 1'b1) begin failures++; $display("FAIL rst_ok_nop got=%b exp=1", ok_o); end
        checks++; if (res_o !== 32'h0) begin failures++; $display("FAIL rst_res got=%h exp=0", res_o); end
        set_bus(32'h1000, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h0);
        #1;
        checks++; if ({dc_req, ok_o} !== 2'b00) begin failures++; $display("FAIL rst_op req/ok got=%b exp=00", {dc_req, ok_o}); end
        set_bus(32'h0, 1'b0, 1'b0, 1'b0, 4'b1111, 32'h0);
        #10 resetn = 1'b1;
        #1;
        checks++; if ({ok_o, ale_o, dc_req} !== 3'b100) begin failures++; $display("FAIL rst_release ok/ale/req got=%b exp=100", {ok_o, ale_o, dc_req}); end
    endtask

    task automatic test_word_load();
        obs_t o; exp_t e;
        exp_q.push_back('{res: 32'hDEAD_BEEF, ale: 1'b0});
        do_txn(32'h1000, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h0, 0, 2, 32'hDEAD_BEEF, o);
        e = exp_q.pop_front();
        checks++; if (o.timeout) begin failures++; $display("FAIL wl_timeout got=timeout exp=done"); end
        checks++; if (o.res !== e.res) begin failures++; $display("FAIL wl_res got=%h exp=%h", o.res, e.res); end
        checks++; if (o.ok_cycle != 2) begin failures++; $display("FAIL wl_latency got=%0d exp=2", o.ok_cycle); end
        checks++; if ({o.addr, o.wstrb, o.wr} !== {32'h1000, 4'b1111, 1'b0}) begin failures++; $display("FAIL wl_req got=%h/%b/%b exp=1000/1111/0", o.addr, o.wstrb, o.wr); end
        checks++; if ({o.res_moved, o.ok_dropped} !== 2'b00) begin failures++; $display("FAIL wl_hold got=%b exp=00", {o.res_moved, o.ok_dropped}); end
        checks++; if (o.hs != 1) begin failures++; $display("FAIL wl_handshakes got=%0d exp=1", o.hs); end
    endtask

    task automatic test_byte_load();
        obs_t o; exp_t e;
        exp_q.push_back('{res: 32'hFFFF_FF80, ale: 1'b0});
        do_txn(32'h1003, 1'b0, 1'b0, 1'b1, 4'b0001, 32'h0, 0, 0, 32'h80FF_1234, o);
        e = exp_q.pop_front();
        checks++; if (o.res !== e.res) begin failures++; $display("FAIL bl_signed got=%h exp=%h", o.res, e.res); end
        checks++; if (o.wstrb !== 4'b1000) begin failures++; $display("FAIL bl_wstrb got=%b exp=1000", o.wstrb); end
        exp_q.push_back('{res: 32'h0000_0080, ale: 1'b0});
        do_txn(32'h1003, 1'b1, 1'b0, 1'b1, 4'b0001, 32'h0, 0, 0, 32'h80FF_1234, o);
        e = exp_q.pop_front();
        checks++; if (o.res !== e.res) begin failures++; $display("FAIL bl_unsigned got=%h exp=%h", o.res, e.res); end
        checks++; if (o.first_req != 0) begin failures++; $display("FAIL bl_b2b_req got=%0d exp=0", o.first_req); end
    endtask

    task automatic test_half_store();
        obs_t o; exp_t e;
        exp_q.push_back('{res: 32'h0, ale: 1'b0});
        do_txn(32'h2002, 1'b0, 1'b1, 1'b0, 4'b0011, 32'h0000_ABCD, 0, 0, 32'h5555_5555, o);
        e = exp_q.pop_front();
        checks++; if ({o.wr, o.addr, o.wstrb, o.wdata} !== {1'b1, 32'h2000, 4'b1100, 32'hABCD_ABCD}) begin failures++; $display("FAIL hs_req got=%b/%h/%b/%h exp=1/2000/1100/abcdabcd", o.wr, o.addr, o.wstrb, o.wdata); end
        checks++; if (o.res !== e.res) begin failures++; $display("FAIL hs_res got=%h exp=%h", o.res, e.res); end
        checks++; if (o.ok_cycle != 2) begin failures++; $display("FAIL hs_latency got=%0d exp=2", o.ok_cycle); end
    endtask

    task automatic test_misaligned();
        obs_t o; exp_t e;
        exp_q.push_back('{res: 32'h0, ale: 1'b1});
        do_txn(32'h3001, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h0, 0, 0, 32'h1111_1111, o);
        e = exp_q.pop_front();
        checks++; if ({o.ale, o.res} !== {e.ale, e.res}) begin failures++; $display("FAIL mis_word ale/res got=%b/%h exp=%b/%h", o.ale, o.res, e.ale, e.res); end
        checks++; if (o.ok_cycle != 0) begin failures++; $display("FAIL mis_word_ok got=%0d exp=0", o.ok_cycle); end
        checks++; if (o.req_cycles != 0) begin failures++; $display("FAIL mis_word_req got=%0d exp=0", o.req_cycles); end
        exp_q.push_back('{res: 32'h0, ale: 1'b1});
        do_txn(32'h5001, 1'b0, 1'b1, 1'b0, 4'b0011, 32'h0, 0, 0, 32'h0, o);
        e = exp_q.pop_front();
        checks++; if ({o.ale, o.req_cycles} != {e.ale, 32'd0}) begin failures++; $display("FAIL mis_half ale/reqs got=%b/%0d exp=1/0", o.ale, o.req_cycles); end
        go_idle();
    endtask

    task automatic test_slow_accept();
        obs_t o; exp_t e;
        exp_q.push_back('{res: 32'hFFFF_F00D, ale: 1'b0});
        do_txn(32'h4002, 1'b0, 1'b0, 1'b1, 4'b0011, 32'h0, 3, 2, 32'hF00D_0000, o);
        e = exp_q.pop_front();
        checks++; if (o.res !== e.res) begin failures++; $display("FAIL sa_res got=%h exp=%h", o.res, e.res); end
        checks++; if ({o.first_req, o.req_cycles} != {32'd0, 32'd4}) begin failures++; $display("FAIL sa_req first/count got=%0d/%0d exp=0/4", o.first_req, o.req_cycles); end
        checks++; if (o.fields_moved !== 1'b0) begin failures++; $display("FAIL sa_stable got=%b exp=0", o.fields_moved); end
        checks++; if (o.ok_cycle != 5) begin failures++; $display("FAIL sa_latency got=%0d exp=5", o.ok_cycle); end
        checks++; if ({o.res_moved, o.ok_dropped, o.hs} != {2'b00, 32'd1}) begin failures++; $display("FAIL sa_done_hold moved/drop/hs got=%b/%b/%0d exp=0/0/1", o.res_moved, o.ok_dropped, o.hs); end
    endtask

    task automatic test_back_to_back();
        obs_t o; exp_t e;
        exp_q.push_back('{res: 32'h0, ale: 1'b0});
        do_txn(32'h2001, 1'b0, 1'b1, 1'b0, 4'b0001, 32'h1234_5678, 0, 0, 32'h0, o);
        e = exp_q.pop_front();
        checks++; if ({o.wstrb, o.wdata, o.res} !== {4'b0010, 32'h7878_7878, e.res}) begin failures++; $display("FAIL bb_store got=%b/%h/%h exp=0010/78787878/%h", o.wstrb, o.wdata, o.res, e.res); end
        exp_q.push_back('{res: 32'h0000_8001, ale: 1'b0});
        do_txn(32'h5002, 1'b1, 1'b0, 1'b1, 4'b0011, 32'h0, 0, 0, 32'h8001_0000, o);
        e = exp_q.pop_front();
        checks++; if (o.res !== e.res) begin failures++; $display("FAIL bb_half_res got=%h exp=%h", o.res, e.res); end
        checks++; if ({o.first_req, o.ok_cycle} != {32'd0, 32'd2}) begin failures++; $display("FAIL bb_timing req/ok got=%0d/%0d exp=0/2", o.first_req, o.ok_cycle); end
        exp_q.push_back('{res: 32'h0, ale: 1'b0});
        do_txn(32'h0, 1'b0, 1'b0, 1'b0, 4'b1111, 32'h0, 0, 0, 32'hFFFF_FFFF, o);
        e = exp_q.pop_front();
        checks++; if ({o.ok_cycle, o.req_cycles} != {32'd0, 32'd0} || o.res !== e.res) begin failures++; $display("FAIL bb_nop ok/reqs/res got=%0d/%0d/%h exp=0/0/%h", o.ok_cycle, o.req_cycles, o.res, e.res); end
        exp_q.push_back('{res: 32'h0BAD_F00D, ale: 1'b0});
        do_txn(32'h6000, 1'b0, 1'b0, 1'b1, 4'b0111, 32'h0, 0, 0, 32'h0BAD_F00D, o);
        e = exp_q.pop_front();
        checks++; if ({o.wstrb, o.res} !== {4'b1111, e.res}) begin failures++; $display("FAIL bb_oddwidth wstrb/res got=%b/%h exp=1111/%h", o.wstrb, o.res, e.res); end
        go_idle();
    endtask

    task automatic test_reset_in_wait();
        @(posedge clk); #1;
        set_bus(32'h7000, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h0);
        dc_addr_ok = 1'b1;
        #1;
        checks++; if (dc_req !== 1'b1) begin failures++; $display("FAIL rw_issue got=%b exp=1", dc_req); end
        @(posedge clk); #1;
        dc_addr_ok = 1'b0;
        #1;
        checks++; if ({dc_req, ok_o} !== 2'b00) begin failures++; $display("FAIL rw_wait req/ok got=%b exp=00", {dc_req, ok_o}); end
        resetn = 1'b0;
        #1;
        checks++; if ({dc_req, ok_o} !== 2'b00) begin failures++; $display("FAIL rw_inreset req/ok got=%b exp=00", {dc_req, ok_o}); end
        set_bus(32'h0, 1'b0, 1'b0, 1'b0, 4'b1111, 32'h0);
        #1 resetn = 1'b1;
        #1;
        checks++; if ({ok_o, dc_req, res_o} !== {2'b10, 32'h0}) begin failures++; $display("FAIL rw_release ok/req/res got=%b/%b/%h exp=1/0/0", ok_o, dc_req, res_o); end
        set_bus(32'h7000, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h0);
        #1;
        checks++; if (dc_req !== 1'b1) begin failures++; $display("FAIL rw_idle_state got=%b exp=1", dc_req); end
        set_bus(32'h0, 1'b0, 1'b0, 1'b0, 4'b1111, 32'h0);
        @(posedge clk); #1;
        checks++; if (ok_o !== 1'b1) begin failures++; $display("FAIL rw_nop_ok got=%b exp=1", ok_o); end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_misaligned();
        test_slow_accept();
        test_back_to_back();
        test_reset_in_wait();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
